// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache sitting
// between the MEM stage and a multi-cycle line-oriented backing memory.
// Build option: define DCACHE_STATS_EN to build saturating hit/miss
// counters; without it stat_hits/stat_misses are tied to 0.
module dcache_wb #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_SETS   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req_valid,
  input  logic                     cpu_req_write,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  output logic                     cpu_ready,
  output logic                     cpu_resp_valid,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_hit,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_write,
  output logic [31:0]              mem_req_addr,
  output logic [32*LINE_WORDS-1:0] mem_req_wdata,
  input  logic                     mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_resp_rdata,
  output logic [31:0]              stat_hits,
  output logic [31:0]              stat_misses
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 32 - 2 - OFF_W - IDX_W;
  localparam int LINE_W = 32 * LINE_WORDS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE,
    S_REFILL
  } state_t;

  state_t state_q, state_d;

  // Latched request; never re-sampled once accepted.
  logic        req_write_q, req_write_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic        first_q, first_d;

  // Registered CPU response.
  logic        resp_valid_q, resp_valid_d;
  logic        resp_hit_q, resp_hit_d;
  logic [31:0] rdata_q, rdata_d;

  // Registered memory request; held stable while waiting for ready.
  logic              mreq_valid_q, mreq_valid_d;
  logic              mreq_write_q, mreq_write_d;
  logic [31:0]       mreq_addr_q, mreq_addr_d;
  logic [LINE_W-1:0] mreq_wdata_q, mreq_wdata_d;

  // Line state: valid/dirty need reset, tags and data do not.
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]   data_mem [NUM_SETS];

  logic store_we;
  logic refill_we;

  // Address fields of the in-flight request.
  logic [OFF_W-1:0]  word_sel;
  logic [IDX_W-1:0]  idx_sel;
  logic [TAG_W-1:0]  tag_sel;
  logic [TAG_W-1:0]  line_tag;
  logic [LINE_W-1:0] line_data;
  logic [31:0]       line_word;
  logic              lookup_hit;
  logic [31:0]       victim_addr;
  logic [31:0]       fill_addr;

  assign word_sel    = req_addr_q[2 +: OFF_W];
  assign idx_sel     = req_addr_q[2 + OFF_W +: IDX_W];
  assign tag_sel     = req_addr_q[31 -: TAG_W];
  assign line_tag    = tag_mem[idx_sel];
  assign line_data   = data_mem[idx_sel];
  assign line_word   = line_data[{word_sel, 5'b00000} +: 32];
  assign lookup_hit  = valid_q[idx_sel] && (line_tag == tag_sel);
  assign victim_addr = {line_tag, idx_sel, {(OFF_W + 2){1'b0}}};
  assign fill_addr   = {tag_sel, idx_sel, {(OFF_W + 2){1'b0}}};

  // Byte-offset bits carry no meaning for word accesses.
  logic unused_byte_bits;
  assign unused_byte_bits = ^{cpu_addr[1:0], req_addr_q[1:0]};

  assign cpu_ready      = (state_q == S_IDLE);
  assign cpu_resp_valid = resp_valid_q;
  assign cpu_rdata      = rdata_q;
  assign cpu_hit        = resp_hit_q;
  assign mem_req_valid  = mreq_valid_q;
  assign mem_req_write  = mreq_write_q;
  assign mem_req_addr   = mreq_addr_q;
  assign mem_req_wdata  = mreq_wdata_q;

  // Next-state, request/response and line-state updates for the controller.
  always_comb begin
    state_d      = state_q;
    req_write_d  = req_write_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    first_d      = first_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    rdata_d      = rdata_q;
    mreq_valid_d = mreq_valid_q;
    mreq_write_d = mreq_write_q;
    mreq_addr_d  = mreq_addr_q;
    mreq_wdata_d = mreq_wdata_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    store_we     = 1'b0;
    refill_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req_valid) begin
          req_write_d = cpu_req_write;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          first_d     = 1'b1;
          state_d     = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (lookup_hit) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = first_q;
          state_d      = S_IDLE;
          if (req_write_q) begin
            store_we         = 1'b1;
            dirty_d[idx_sel] = 1'b1;
            rdata_d          = req_wdata_q;
          end else begin
            rdata_d = line_word;
          end
        end else begin
          // Only the first lookup may report a hit.
          first_d      = 1'b0;
          mreq_valid_d = 1'b1;
          if (valid_q[idx_sel] && dirty_q[idx_sel]) begin
            mreq_write_d = 1'b1;
            mreq_addr_d  = victim_addr;
            mreq_wdata_d = line_data;
            state_d      = S_WRITEBACK;
          end else begin
            mreq_write_d = 1'b0;
            mreq_addr_d  = fill_addr;
            state_d      = S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        if (mem_req_ready) begin
          mreq_write_d = 1'b0;
          mreq_addr_d  = fill_addr;
          state_d      = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        if (mem_req_ready) begin
          mreq_valid_d = 1'b0;
          state_d      = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_resp_valid) begin
          refill_we        = 1'b1;
          valid_d[idx_sel] = 1'b1;
          dirty_d[idx_sel] = 1'b0;
          state_d          = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_write_q  <= 1'b0;
      req_addr_q   <= 32'd0;
      req_wdata_q  <= 32'd0;
      first_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      rdata_q      <= 32'd0;
      mreq_valid_q <= 1'b0;
      mreq_write_q <= 1'b0;
      mreq_addr_q  <= 32'd0;
      mreq_wdata_q <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_write_q  <= req_write_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      first_q      <= first_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      rdata_q      <= rdata_d;
      mreq_valid_q <= mreq_valid_d;
      mreq_write_q <= mreq_write_d;
      mreq_addr_q  <= mreq_addr_d;
      mreq_wdata_q <= mreq_wdata_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
    end
  end

  // Tag/data storage: whole-line refill or single-word store merge.
  always_ff @(posedge clk) begin
    if (refill_we) begin
      data_mem[idx_sel] <= mem_resp_rdata;
      tag_mem[idx_sel]  <= tag_sel;
    end else if (store_we) begin
      data_mem[idx_sel][{word_sel, 5'b00000} +: 32] <= req_wdata_q;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hits_q, hits_d;
  logic [31:0] misses_q, misses_d;

  // Saturating counters bumped on the edge that registers a response.
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (resp_valid_d) begin
      if (resp_hit_d) begin
        if (hits_q != 32'hFFFF_FFFF) hits_d = hits_q + 32'd1;
      end else begin
        if (misses_q != 32'hFFFF_FFFF) misses_d = misses_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hits_q   <= 32'd0;
      misses_q <= 32'd0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = 32'd0;
  assign stat_misses = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: scoreboard bench for dcache_wb. Requests are scored against a
// line-level reference model (golden memory + per-set valid/dirty/tag);
// expected CPU responses and memory requests are queued at issue time and
// popped by independent monitor/memory processes.
module tb_dcache_wb;
  localparam int LW     = 4;
  localparam int NS     = 16;
  localparam int LINE_W = 32 * LW;
  localparam int LBYTES = LW * 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req_valid, cpu_req_write;
  logic [31:0]       cpu_addr, cpu_wdata;
  logic              cpu_ready, cpu_resp_valid, cpu_hit;
  logic [31:0]       cpu_rdata;
  logic              mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0]       mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_rdata;
  logic [31:0]       stat_hits, stat_misses;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  dcache_wb #(.LINE_WORDS(LW), .NUM_SETS(NS)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid),
    .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] rdata; logic hit; int due; } resp_exp_t;
  typedef struct { logic write; logic [31:0] addr; logic [LINE_W-1:0] wdata; } mem_exp_t;
  resp_exp_t resp_q[$];
  mem_exp_t  mem_q[$];

  logic [31:0] golden  [int unsigned];
  logic [31:0] backing [int unsigned];
  bit          m_valid [NS];
  bit          m_dirty [NS];
  int unsigned m_tag   [NS];
  int          exp_hits, exp_misses;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    if (golden.exists(a)) return golden[a];
    return init_val(a);
  endfunction
  function automatic logic [31:0] back_rd(input logic [31:0] a);
    if (backing.exists(a)) return backing[a];
    return init_val(a);
  endfunction
  function automatic logic [LINE_W-1:0] gold_line(input logic [31:0] base);
    logic [LINE_W-1:0] l;
    for (int w = 0; w < LW; w++) l[w*32 +: 32] = gold_rd(base + 32'(w * 4));
    return l;
  endfunction
  function automatic logic [LINE_W-1:0] back_line(input logic [31:0] base);
    logic [LINE_W-1:0] l;
    for (int w = 0; w < LW; w++) l[w*32 +: 32] = back_rd(base + 32'(w * 4));
    return l;
  endfunction
  function automatic logic [31:0] exp_stat(input int n);
`ifdef DCACHE_STATS_EN
    return 32'(n);
`else
    return 32'(n) & 32'd0;
`endif
  endfunction

  // Reset drops cache contents: unflushed stores are lost.
  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin m_valid[s] = 0; m_dirty[s] = 0; m_tag[s] = 0; end
    golden.delete();
    foreach (backing[k]) golden[k] = backing[k];
    resp_q.delete();
    mem_q.delete();
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic model_issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input int drive_cyc);
    logic [31:0] a, base, vbase, r;
    int unsigned set, tg;
    bit hit;
    mem_exp_t me;
    resp_exp_t re;
    a    = addr & ~32'h3;
    base = a & ~32'(LBYTES - 1);
    set  = (a / LBYTES) % NS;
    tg   = a / (LBYTES * NS);
    hit  = m_valid[set] && (m_tag[set] == tg);
    if (!hit) begin
      if (m_valid[set] && m_dirty[set]) begin
        vbase = 32'((m_tag[set] * NS + set) * LBYTES);
        me.write = 1'b1; me.addr = vbase; me.wdata = gold_line(vbase);
        mem_q.push_back(me);
      end
      me.write = 1'b0; me.addr = base; me.wdata = '0;
      mem_q.push_back(me);
      m_valid[set] = 1; m_dirty[set] = 0; m_tag[set] = tg;
    end
    if (wr) begin
      golden[a] = wd;
      m_dirty[set] = 1;
      r = wd;
    end else begin
      r = gold_rd(a);
    end
    re.rdata = r; re.hit = hit; re.due = hit ? drive_cyc + 2 : -1;
    resp_q.push_back(re);
    if (hit) exp_hits++; else exp_misses++;
  endtask

  // ---------------- driver ----------------
  bit timed_out = 0;
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (!cpu_ready && n < 500) begin @(negedge clk); n++; end
    if (!cpu_ready) begin
      checks++; errors++; timed_out = 1;
      $display("FAIL ready_timeout: cpu_ready got 0 expected 1 addr=%0h", addr);
      return;
    end
    cpu_req_valid = 1; cpu_req_write = wr; cpu_addr = addr; cpu_wdata = wd;
    model_issue(wr, addr, wd, cyc);
    $display("REQ %s addr=%08h wdata=%08h cyc=%0d", wr ? "ST" : "LD", addr, wd, cyc);
    @(negedge clk);
    cpu_req_valid = 0;
    cpu_req_write = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((resp_q.size() != 0 || mem_q.size() != 0) && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (resp_q.size() != 0 || mem_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: resp_left=%0d mem_left=%0d expected 0", resp_q.size(), mem_q.size());
      resp_q.delete(); mem_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tagn);
    chk({tagn, "_cpu_ready"}, cpu_ready, 1'b1);
    chk({tagn, "_resp_valid"}, cpu_resp_valid, 1'b0);
    chk({tagn, "_rdata"}, cpu_rdata, 32'd0);
    chk({tagn, "_hit"}, cpu_hit, 1'b0);
    chk({tagn, "_mreq_valid"}, mem_req_valid, 1'b0);
    chk({tagn, "_mreq_write"}, mem_req_write, 1'b0);
    chk({tagn, "_mreq_addr"}, mem_req_addr, 32'd0);
    chk({tagn, "_mreq_wdata"}, mem_req_wdata, '0);
    chk({tagn, "_stat_hits"}, stat_hits, 32'd0);
    chk({tagn, "_stat_misses"}, stat_misses, 32'd0);
  endtask

  // ---------------- response monitor ----------------
  resp_exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && cpu_resp_valid) begin
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got rdata=%0h expected no response", cpu_rdata);
        end else begin
          mon_e = resp_q.pop_front();
          $display("RESP rdata=%08h hit=%0b exp_rdata=%08h exp_hit=%0b cyc=%0d", cpu_rdata, cpu_hit, mon_e.rdata, mon_e.hit, cyc);
          chk("resp_rdata", cpu_rdata, mon_e.rdata);
          chk("resp_hit", cpu_hit, mon_e.hit);
          chk("ready_with_resp", cpu_ready, 1'b1);
          if (mon_e.due >= 0) chk("hit_latency", cyc, mon_e.due);
        end
      end
    end
  end

  // ---------------- memory model / request monitor ----------------
  int                bp_each = 0;
  bit                hold_resp = 0;
  bit                late_pulse = 0;
  int                dly_min = 1, dly_max = 4;
  int                rd_hs = 0, wr_hs = 0;
  bit                stalled = 0;
  int                bp_rem = 0, cd = 0;
  logic              sv_write;
  logic [31:0]       sv_addr;
  logic [LINE_W-1:0] sv_wdata, pend_line;
  mem_exp_t          mm_e;

  initial begin
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 0;
      if (reset) begin
        mem_req_ready = 0; stalled = 0; cd = 0;
        continue;
      end
      if (late_pulse) begin
        mem_resp_valid = 1; mem_resp_rdata = {LW{32'hBAD0_BAD0}}; late_pulse = 0;
      end else if (cd > 0 && !hold_resp) begin
        cd--;
        if (cd == 0) begin mem_resp_valid = 1; mem_resp_rdata = pend_line; end
      end
      mem_req_ready = 0;
      if (mem_req_valid) begin
        if (stalled) begin
          chk("hold_write", mem_req_write, sv_write);
          chk("hold_addr", mem_req_addr, sv_addr);
          if (sv_write) chk("hold_wdata", mem_req_wdata, sv_wdata);
        end else begin
          bp_rem = bp_each;
        end
        if (bp_rem > 0) begin
          bp_rem--;
          mem_req_ready = 0;
        end else begin
          mem_req_ready = (bp_each > 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
        if (mem_req_ready) begin
          stalled = 0;
          $display("MEM %s addr=%08h cyc=%0d", mem_req_write ? "WB" : "RD", mem_req_addr, cyc);
          if (mem_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem_req: got addr=%0h expected none", mem_req_addr);
          end else begin
            mm_e = mem_q.pop_front();
            chk("mreq_write", mem_req_write, mm_e.write);
            chk("mreq_addr", mem_req_addr, mm_e.addr);
            if (mm_e.write) chk("mreq_wdata", mem_req_wdata, mm_e.wdata);
          end
          if (mem_req_write) begin
            for (int w = 0; w < LW; w++) backing[mem_req_addr + 32'(w * 4)] = mem_req_wdata[w*32 +: 32];
            wr_hs++;
          end else begin
            pend_line = back_line(mem_req_addr);
            cd = $urandom_range(dly_min, dly_max);
            rd_hs++;
          end
        end else begin
          stalled = 1; sv_write = mem_req_write; sv_addr = mem_req_addr; sv_wdata = mem_req_wdata;
        end
      end else begin
        stalled = 0;
      end
    end
  end

  // ---------------- main sequence ----------------
  int rd0, n;
  logic [31:0] ra;
  initial begin
    reset = 1; cpu_req_valid = 0; cpu_req_write = 0; cpu_addr = 0; cpu_wdata = 0;
    model_reset();
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    reset = 0;

    // Known line at 0x10..0x1C.
    backing[32'h10] = 32'h11; backing[32'h14] = 32'h22;
    backing[32'h18] = 32'h33; backing[32'h1C] = 32'h44;
    foreach (backing[k]) golden[k] = backing[k];

    // Miss then hit; store hit; dirty eviction under backpressure.
    do_req(1'b0, 32'h0000_0010, 32'h0);
    do_req(1'b0, 32'h0000_0014, 32'h0);
    wait_idle();
    do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    wait_idle();
    bp_each = 5;
    do_req(1'b0, 32'h0000_0110, 32'h0);
    wait_idle();
    bp_each = 0;

    // Randomized traffic over a few sets and tags to force conflicts.
    for (int i = 0; i < 250 && !timed_out; i++) begin
      ra = 32'(($urandom_range(0, 3) * NS + $urandom_range(0, 3)) * LBYTES)
         + 32'($urandom_range(0, LW - 1) * 4) + 32'($urandom_range(0, 3));
      do_req(1'($urandom), ra, $urandom);
    end
    wait_idle();
    chk("stat_hits_rand", stat_hits, exp_stat(exp_hits));
    chk("stat_misses_rand", stat_misses, exp_stat(exp_misses));

    // Reset while a refill is outstanding.
    hold_resp = 1;
    rd0 = rd_hs;
    do_req(1'b0, 32'h7000_0040, 32'h0);
    n = 0;
    while (rd_hs == rd0 && n < 200) begin @(negedge clk); n++; end
    chk("refill_reached", 32'(rd_hs != rd0), 32'd1);
    @(negedge clk); @(negedge clk);
    #2; reset = 1;
    model_reset();
    #1;
    check_reset_outputs("mid");
    @(negedge clk); @(negedge clk);
    reset = 0;
    hold_resp = 0;
    late_pulse = 1;
    repeat (4) begin
      @(negedge clk);
      chk("late_resp_ready", cpu_ready, 1'b1);
      chk("late_resp_mreq", mem_req_valid, 1'b0);
    end

    // Reload 0x10 (miss) while poking a request during the refill.
    dly_min = 6; dly_max = 6;
    rd0 = rd_hs;
    do_req(1'b0, 32'h0000_0010, 32'h0);
    n = 0;
    while (rd_hs == rd0 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    cpu_req_valid = 1; cpu_req_write = 0; cpu_addr = 32'h20;
    chk("busy_ready_low", cpu_ready, 1'b0);
    @(negedge clk);
    cpu_req_valid = 0;
    n = 0;
    while (resp_q.size() != 0 && n < 100) begin
      if (!cpu_resp_valid) chk("busy_ready_wait", cpu_ready, 1'b0);
      @(negedge clk); n++;
    end
    wait_idle();
    repeat (3) begin
      @(negedge clk);
      chk("busy_ignored_mreq", mem_req_valid, 1'b0);
    end
    dly_min = 1; dly_max = 4;

    // Counter sequence after reset: miss, hit, hit, miss.
    @(negedge clk); #2; reset = 1; model_reset();
    @(negedge clk); reset = 0;
    do_req(1'b0, 32'h0000_0010, 32'h0);
    do_req(1'b0, 32'h0000_0014, 32'h0);
    do_req(1'b1, 32'h0000_0018, 32'h5A5A_0001);
    do_req(1'b0, 32'h0000_0110, 32'h0);
    wait_idle();
    chk("stat_hits_seq", stat_hits, exp_stat(exp_hits));
    chk("stat_misses_seq", stat_misses, exp_stat(exp_misses));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Data cache between the pipeline's MEM stage (upstream requester) and a multi-cycle backing data memory (downstream).
- Direct-mapped, write-back, write-allocate.
- The MEM stage stalls while cpu_ready is low or a response is pending.
- Line refill and eviction use a valid/ready handshake toward memory, so memory latency is arbitrary.

Parameters:
LINE_WORDS, 4, 32-bit words per line (power of 2, >=2)
NUM_SETS, 16, number of lines (power of 2, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
cpu_req_valid  in  1  MEM stage request present
cpu_req_write  in  1  1=store, 0=load
cpu_addr  in  32  byte address; bits [1:0] ignored
cpu_wdata  in  32  store data
cpu_ready  out  1  cache can accept a request this cycle
cpu_resp_valid  out  1  one-cycle pulse: request complete
cpu_rdata  out  32  load data, valid with cpu_resp_valid
cpu_hit  out  1  with cpu_resp_valid: 1=hit on first lookup
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  1=line writeback, 0=line read
mem_req_addr  out  32  line-aligned byte address
mem_req_wdata  out  32*LINE_WORDS  writeback line, word0 in LSBs
mem_resp_valid  in  1  refill data present (read only)
mem_resp_rdata  in  32*LINE_WORDS  refill line, word0 in LSBs
stat_hits  out  32  hit counter (see Optional Feature)
stat_misses  out  32  miss counter (see Optional Feature)

Behaviour:
- Address split: [1:0] byte; next log2(LINE_WORDS) bits word; next log2(NUM_SETS) bits index; remaining upper bits tag.
- Per line: valid, dirty, tag, data.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, REFILL.
- Reset, asynchronous:
  - state=IDLE; all valid/dirty bits cleared.
  - cpu_ready=1; cpu_resp_valid=0, cpu_hit=0, cpu_rdata=0.
  - mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_req_wdata=0.
  - Stats=0.
  - Any in-flight request is dropped.
- Accept:
  - cpu_ready=1 only in IDLE.
  - The request is accepted on an edge with cpu_req_valid && cpu_ready; write, addr and wdata are latched.
  - State goes to COMPARE and a first-lookup flag is set.
  - cpu_req_valid while not ready is ignored; inputs are not re-sampled after acceptance.
- COMPARE, hit (valid && tag match):
  - Store writes its word and sets dirty; load reads its word.
  - At the edge, register cpu_resp_valid=1, cpu_rdata, cpu_hit=first-lookup flag; return to IDLE.
  - Hit latency: response visible the cycle after COMPARE, with cpu_ready=1 in that same cycle.
  - cpu_resp_valid is a single-cycle pulse.
  - cpu_rdata holds until the next response.
  - Store responses drive cpu_rdata with the stored word.
- COMPARE, miss:
  - Clear the first-lookup flag.
  - Line valid && dirty -> WRITEBACK; otherwise -> ALLOCATE.
- WRITEBACK:
  - mem_req_valid=1, write=1, addr={old tag, index, 0}, wdata=old line.
  - Hold all request fields stable until mem_req_ready; on the handshake edge -> ALLOCATE.
- ALLOCATE:
  - mem_req_valid=1, write=0, addr={new tag, index, 0}.
  - Hold until mem_req_ready, then -> REFILL.
- REFILL:
  - mem_req_valid=0.
  - On mem_resp_valid: write the line, valid=1, dirty=0, tag=new; -> COMPARE.
  - The second COMPARE hits; the store merges its word and sets dirty; cpu_hit=0.
- mem_resp_valid outside REFILL is ignored. Memory never responds in the same cycle its request is accepted.
- Miss with clean victim: exactly one memory request. Miss with dirty victim: exactly two, writeback first.
- Same-index different-tag accesses always evict; there is no victim buffer.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined:
  - stat_hits increments on each response with cpu_hit=1.
  - stat_misses increments on each response with cpu_hit=0.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: counters are not built; stat_hits and stat_misses are constant 0.
- Ports exist in both builds.

Test Plan:
- Miss then hit:
  - After reset, load 0x00000010 -> mem read req addr 0x10.
  - Respond line {0x44,0x33,0x22,0x11} -> resp rdata=0x11, hit=0.
  - Load 0x14 -> rdata=0x22, hit=1, response 2 edges after accept, no mem_req_valid.
- Dirty eviction:
  - Store 0xDEADBEEF to 0x10 (hit).
  - Load 0x110 -> writeback req addr 0x10, wdata word0=0xDEADBEEF, then read req addr 0x110; resp hit=0.
- Backpressure: hold mem_req_ready=0 for 5 cycles in WRITEBACK and in ALLOCATE -> mem_req_valid/write/addr/wdata stable throughout; exactly one handshake each.
- Busy ignore: pulse cpu_req_valid with addr 0x20 during REFILL of 0x10 -> ignored; only 0x10 completes; cpu_ready low until the response cycle.
- Reset mid-refill:
  - Assert reset in REFILL -> mem_req_valid, cpu_resp_valid, cpu_ready outputs at reset values immediately.
  - Late mem_resp_valid ignored.
  - Reload 0x10 -> miss.
- With DCACHE_STATS_EN: sequence miss, hit, hit, miss -> stat_hits=2, stat_misses=2. Without the macro both read 0.
